// File: rtl/cam_pkg.sv
// Shared camera-path definitions: snapshot FSM encoding and default frame geometry.
package cam_pkg;

  // Default geometry and timing of the 640x480 RGB444 frame buffer path
  localparam int CAM_FRAME_PIXELS = 307200;
  localparam int CAM_ADDR_W       = 19;
  localparam int CAM_PIX_W        = 12;
  localparam int CAM_RD_LAT       = 2;
  localparam int CAM_SETTLE       = 4;
  localparam int CAM_FIFO_DEPTH   = 4;

  // Snapshot streamer sequencing
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4,
    ST_FLUSH  = 3'd5
  } snap_state_t;

endpackage

// File: rtl/snap_fifo.sv
// Small synchronous skid FIFO holding returned pixels plus their SOF/EOF flags.
module snap_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/frame_snapshot_streamer.sv
// Freezes the frame buffer, sweeps it once and streams every pixel out with SOF/EOF marks.
module frame_snapshot_streamer
  import cam_pkg::*;
#(
  parameter int FRAME_PIXELS = CAM_FRAME_PIXELS,
  parameter int ADDR_W       = CAM_ADDR_W,
  parameter int PIX_W        = CAM_PIX_W,
  parameter int RD_LAT       = CAM_RD_LAT,
  parameter int SETTLE       = CAM_SETTLE,
  parameter int FIFO_DEPTH   = CAM_FIFO_DEPTH
) (
  input  logic              clk100,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              freeze_frame,
  output logic [ADDR_W-1:0] axi_address,
  input  logic [PIX_W-1:0]  axi_pixel,
  output logic [PIX_W-1:0]  m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  snap_state_t       state;
  snap_state_t       next_state;
  logic [15:0]       timer;
  logic [ADDR_W-1:0] rd_addr;
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] sof_pipe;
  logic [RD_LAT-1:0] eof_pipe;
  logic [LAT_W-1:0]  inflight;
  int                occupancy;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clear;
  logic [PIX_W+1:0]  fifo_din;
  logic [PIX_W+1:0]  fifo_dout;
  logic              abort_req;
  logic              issue;
  logic              last_issue;

  // Credit accounting: reads still in the latency pipe plus pixels already queued
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + LAT_W'(vld_pipe[i]);
    end
  end

  assign occupancy  = int'(fifo_count) + int'(inflight);
  assign abort_req  = abort && (state == ST_SETTLE || state == ST_STREAM || state == ST_DRAIN);
  assign issue      = (state == ST_STREAM) && !abort && (occupancy < FIFO_DEPTH);
  assign last_issue = issue && (rd_addr == LAST_ADDR);

  // Returning reads are discarded once an abort is taken
  assign fifo_push  = vld_pipe[RD_LAT-1] && (state != ST_FLUSH) && !abort_req;
  assign fifo_pop   = m_tvalid && m_tready;
  assign fifo_clear = abort_req;
  assign fifo_din   = {sof_pipe[RD_LAT-1], eof_pipe[RD_LAT-1], axi_pixel};

  snap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W + 2)
  ) u_fifo (
    .clk     (clk100),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .clear   (fifo_clear),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  // State register
  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start only counts in IDLE, so it beats a simultaneous abort there
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_SETTLE;
      ST_SETTLE: begin
        if (abort)                            next_state = ST_FLUSH;
        else if (timer == 16'(SETTLE - 1))    next_state = ST_STREAM;
      end
      ST_STREAM: begin
        if (abort)                            next_state = ST_FLUSH;
        else if (last_issue)                  next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)                            next_state = ST_FLUSH;
        else if (inflight == '0 && fifo_empty) next_state = ST_DONE;
      end
      ST_DONE:   next_state = ST_IDLE;
      ST_FLUSH:  if (timer == 16'(RD_LAT - 1)) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Per-state dwell timer, restarted on every state change
  always_ff @(posedge clk100) begin
    if (!reset_n || state != next_state) begin
      timer <= '0;
    end else begin
      timer <= timer + 16'd1;
    end
  end

  // Address sweep and latency pipe that tags each read with its frame-boundary flags
  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      rd_addr     <= '0;
      axi_address <= '0;
      vld_pipe    <= '0;
      sof_pipe    <= '0;
      eof_pipe    <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        sof_pipe[i] <= sof_pipe[i-1];
        eof_pipe[i] <= eof_pipe[i-1];
      end
      vld_pipe[0] <= issue;
      sof_pipe[0] <= issue && (rd_addr == '0);
      eof_pipe[0] <= last_issue;
      if (next_state == ST_IDLE) begin
        rd_addr     <= '0;
        axi_address <= '0;
      end else if (issue) begin
        axi_address <= rd_addr;
        rd_addr     <= rd_addr + ADDR_W'(1);
      end
    end
  end

  // One-cycle notice that the snapshot was cut short, raised as IDLE is re-entered
  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      aborted <= 1'b0;
    end else begin
      aborted <= (state == ST_FLUSH) && (next_state == ST_IDLE);
    end
  end

  // State-decoded outputs; stream fields read as zero whenever nothing is offered
  always_comb begin
    freeze_frame = (state == ST_SETTLE) || (state == ST_STREAM) ||
                   (state == ST_DRAIN)  || (state == ST_FLUSH);
    busy         = (state != ST_IDLE);
    done         = (state == ST_DONE);
    m_tvalid     = !fifo_empty;
    m_tdata      = '0;
    m_tuser      = 1'b0;
    m_tlast      = 1'b0;
    if (!fifo_empty) begin
      m_tdata = fifo_dout[PIX_W-1:0];
      m_tuser = fifo_dout[PIX_W+1];
      m_tlast = fifo_dout[PIX_W];
    end
  end

endmodule

// File: tb/tb_frame_snapshot_streamer.sv
// Directed bench for frame_snapshot_streamer on a 16-pixel frame.
module tb_frame_snapshot_streamer;

  localparam int FRAME_PIXELS = 16;
  localparam int ADDR_W       = 19;
  localparam int PIX_W        = 12;
  localparam int RD_LAT       = 2;
  localparam int SETTLE       = 4;
  localparam int FIFO_DEPTH   = 4;

  logic              clk100;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic              freeze_frame;
  logic [ADDR_W-1:0] axi_address;
  logic [PIX_W-1:0]  axi_pixel;
  logic [PIX_W-1:0]  m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tuser;
  logic              m_tlast;
  logic              busy;
  logic              done;
  logic              aborted;

  int total = 0;
  int bad   = 0;

  frame_snapshot_streamer #(
    .FRAME_PIXELS (FRAME_PIXELS),
    .ADDR_W       (ADDR_W),
    .PIX_W        (PIX_W),
    .RD_LAT       (RD_LAT),
    .SETTLE       (SETTLE),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clk100       (clk100),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .freeze_frame (freeze_frame),
    .axi_address  (axi_address),
    .axi_pixel    (axi_pixel),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tuser      (m_tuser),
    .m_tlast      (m_tlast),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  // Frame buffer model: address registered by the DUT at edge N is captured back at edge N+2
  logic [PIX_W-1:0] buf_q;
  always @(posedge clk100) buf_q <= axi_address[PIX_W-1:0] + 12'h100;
  assign axi_pixel = buf_q;

  // Stream monitor: records accepted beats, pulse counts, stall stability and FIFO peak
  logic [13:0] beats[$];
  int          beat_cyc[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          aborted_cnt = 0;
  int          freeze_at_done = 0;
  int          unstable = 0;
  int          fifo_max = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [13:0] prev_beat = '0;

  always @(negedge clk100) begin
    cyc++;
    if (m_tvalid && m_tready) begin
      beats.push_back({m_tuser, m_tlast, m_tdata});
      beat_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      if (freeze_frame) freeze_at_done++;
    end
    if (aborted) aborted_cnt++;
    if (prev_valid && !prev_ready && reset_n && !aborted) begin
      if (!m_tvalid || {m_tuser, m_tlast, m_tdata} != prev_beat) unstable++;
    end
    if (int'(dut.fifo_count) > fifo_max) fifo_max = int'(dut.fifo_count);
    prev_valid = m_tvalid;
    prev_ready = m_tready;
    prev_beat  = {m_tuser, m_tlast, m_tdata};
  end

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic rdy);
    start    = st;
    abort    = ab;
    m_tready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearMonitor();
    beats.delete();
    beat_cyc.delete();
    done_cnt       = 0;
    aborted_cnt    = 0;
    freeze_at_done = 0;
    unstable       = 0;
    fifo_max       = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_flags"}, 32'({freeze_frame, busy, done, aborted, m_tvalid, m_tuser, m_tlast}), 32'd0);
    checkOutput({tag, "_tdata"}, 32'(m_tdata), 32'd0);
    checkOutput({tag, "_addr"}, 32'(axi_address), 32'd0);
  endtask

  // Steps until m_tvalid rises; n carries the cycle count since the start edge
  task automatic waitValid(input string tag, input int bound, inout int n);
    while (!m_tvalid && n < bound) begin
      step();
      n++;
    end
    checkOutput({tag, "_valid_seen"}, 32'(m_tvalid), 32'd1);
  endtask

  // Steps until the DUT is idle again, with constant or random ready
  task automatic waitIdle(input string tag, input int bound, input bit rand_ready);
    int n = 0;
    while (busy && n < bound) begin
      if (rand_ready) m_tready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    m_tready = 1'b1;
    checkOutput({tag, "_idle_reached"}, 32'(busy), 32'd0);
  endtask

  task automatic checkFrame(input string tag);
    logic [13:0] exp;
    checkOutput({tag, "_beat_count"}, 32'(beats.size()), 32'(FRAME_PIXELS));
    for (int i = 0; i < beats.size() && i < FRAME_PIXELS; i++) begin
      exp = {(i == 0), (i == FRAME_PIXELS - 1), 12'(12'h100 + i)};
      checkOutput($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(exp));
    end
    checkOutput({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    checkOutput({tag, "_freeze_at_done"}, 32'(freeze_at_done), 32'd0);
  endtask

  initial begin
    int lat;

    // Reset
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (3) step();
    checkAllZero("reset");
    reset_n = 1'b1;
    step();
    checkOutput("reset_idle_busy", 32'(busy), 32'd0);

    // 1: full-rate frame
    $display("[TB] scenario 1: full-rate frame");
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_freeze_up", 32'(freeze_frame), 32'd1);
    checkOutput("t1_busy_up", 32'(busy), 32'd1);
    lat = 0;
    waitValid("t1", 50, lat);
    checkOutput("t1_first_latency", 32'(lat), 32'd7);
    checkOutput("t1_first_tdata", 32'(m_tdata), 32'h100);
    checkOutput("t1_first_tuser", 32'(m_tuser), 32'd1);
    waitIdle("t1", 100, 1'b0);
    checkFrame("t1");
    if (beat_cyc.size() >= FRAME_PIXELS)
      checkOutput("t1_back_to_back", 32'(beat_cyc[FRAME_PIXELS-1] - beat_cyc[0]), 32'(FRAME_PIXELS - 1));
    checkOutput("t1_no_abort", 32'(aborted_cnt), 32'd0);

    // 2: random backpressure
    $display("[TB] scenario 2: random ready");
    step();
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitIdle("t2", 600, 1'b1);
    checkFrame("t2");
    checkOutput("t2_stable_while_stalled", 32'(unstable), 32'd0);
    checkOutput("t2_fifo_within_depth", 32'(fifo_max <= FIFO_DEPTH), 32'd1);

    // 3: long stall from the first beat
    $display("[TB] scenario 3: long stall");
    step();
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    lat = 0;
    waitValid("t3", 50, lat);
    repeat (20) step();
    checkOutput("t3_no_beats_while_stalled", 32'(beats.size()), 32'd0);
    checkOutput("t3_last_issued_addr", 32'(axi_address), 32'd3);
    checkOutput("t3_fifo_full", 32'(dut.fifo_count), 32'd4);
    checkOutput("t3_head_held", 32'({m_tuser, m_tdata}), 32'h1100);
    m_tready = 1'b1;
    waitIdle("t3", 100, 1'b0);
    checkFrame("t3");

    // 4: abort at the 6th beat, then a fresh frame
    $display("[TB] scenario 4: abort");
    step();
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    lat = 0;
    while (!(m_tvalid && m_tdata == 12'h105) && lat < 50) begin
      step();
      lat++;
    end
    checkOutput("t4_sixth_beat_seen", 32'(m_tdata), 32'h105);
    applyStimulus(1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4_tvalid_dropped", 32'(m_tvalid), 32'd0);
    checkOutput("t4_freeze_in_flush", 32'(freeze_frame), 32'd1);
    checkOutput("t4_aborted_early", 32'(aborted), 32'd0);
    step();
    checkOutput("t4_aborted_still_low", 32'(aborted), 32'd0);
    step();
    checkOutput("t4_aborted_pulse", 32'(aborted), 32'd1);
    checkOutput("t4_freeze_low", 32'(freeze_frame), 32'd0);
    checkOutput("t4_busy_low", 32'(busy), 32'd0);
    checkOutput("t4_addr_home", 32'(axi_address), 32'd0);
    step();
    checkOutput("t4_aborted_one_cycle", 32'(aborted), 32'd0);
    checkOutput("t4_no_done", 32'(done_cnt), 32'd0);
    checkOutput("t4_beats_before_abort", 32'(beats.size()), 32'd6);
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitIdle("t4b", 100, 1'b0);
    checkFrame("t4b");

    // 5: start while busy, abort in IDLE, start with abort in IDLE
    $display("[TB] scenario 5: ignored requests");
    step();
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    lat = 2;
    waitValid("t5", 50, lat);
    checkOutput("t5_latency_unchanged", 32'(lat), 32'd7);
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitIdle("t5", 100, 1'b0);
    checkFrame("t5");
    step();
    applyStimulus(1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t5_idle_abort_busy", 32'(busy), 32'd0);
    step();
    checkOutput("t5_idle_abort_no_pulse", 32'(aborted), 32'd0);
    clearMonitor();
    applyStimulus(1'b1, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t5_start_wins_busy", 32'(busy), 32'd1);
    checkOutput("t5_start_wins_freeze", 32'(freeze_frame), 32'd1);
    waitIdle("t5b", 100, 1'b0);
    checkFrame("t5b");
    checkOutput("t5b_no_abort", 32'(aborted_cnt), 32'd0);

    // 6: reset mid-stream, then a complete frame
    $display("[TB] scenario 6: reset mid-stream");
    step();
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    lat = 0;
    while (!(m_tvalid && m_tdata == 12'h103) && lat < 50) begin
      step();
      lat++;
    end
    checkOutput("t6_mid_stream", 32'(m_tdata), 32'h103);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checkAllZero("t6_after_reset");
    step();
    checkOutput("t6_still_idle", 32'(busy), 32'd0);
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitIdle("t6", 100, 1'b0);
    checkFrame("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
